// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the subordinate data-phase state type.
// Also imported by the master-side bench.
package ahb_lite_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAct,
    StErr1,
    StErr2
  } slave_state_e;

  // Little-endian lane enables; only meaningful for legal (aligned, size <= 2) transfers.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    unique case (size)
      HsizeByte: be = 4'b0001 << addr;
      HsizeHalf: be = 4'b0011 << {addr[1], 1'b0};
      default:   be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
module ahb_byte_ram #(
  parameter int unsigned Aw = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**Aw];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate in front of an on-chip byte-enabled SRAM, with
// configurable OKAY wait states and two-cycle ERROR for illegal accesses.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned WordAw = ADDR_W - 2;

  slave_state_e      state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WordAw-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [3:0]        be_q, be_d;

  logic        accept, illegal, phase_end, ram_we;
  logic [31:0] ram_rdata;

  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = (HSIZE > HsizeWord)
                 | ((HSIZE == HsizeHalf) & HADDR[0])
                 | ((HSIZE == HsizeWord) & (HADDR[1:0] != 2'b00))
                 | (HADDR[31:ADDR_W] != '0);

  // States whose HREADYOUT is high: the current data phase ends on this edge.
  assign phase_end = (state_q == StIdle) | (state_q == StAct) | (state_q == StErr2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    be_d      = be_q;
    HREADYOUT = 1'b1;
    HRESP     = HrespOkay;

    unique case (state_q)
      StWait: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 3'd0) begin
          state_d = StAct;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = HrespError;
        state_d   = StErr2;
      end
      StErr2:  HRESP = HrespError;
      default: ;
    endcase

    if (phase_end) begin
      if (accept) begin
        addr_d  = HADDR[ADDR_W-1:2];
        write_d = HWRITE;
        be_d    = byte_enable(HSIZE, HADDR[1:0]);
        if (illegal) begin
          state_d = StErr1;
        end else if (WAIT_STATES > 0) begin
          state_d = StWait;
          cnt_d   = 3'(WAIT_STATES - 1);
        end else begin
          state_d = StAct;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      be_q    <= be_d;
    end
  end

  assign ram_we = (state_q == StAct) & write_q;
  assign HRDATA = ((state_q == StAct) & ~write_q) ? ram_rdata : 32'h0;

  ahb_byte_ram #(
    .Aw(WordAw)
  ) u_ram (
    .clk_i  (HCLK),
    .we_i   (ram_we),
    .be_i   (be_q),
    .addr_i (addr_q),
    .wdata_i(HWDATA),
    .rdata_o(ram_rdata)
  );

endmodule
